banked_mem_responder: RTL

Four-bank interleaved main-memory responder serving the cache controller's memory-side interface (fm_addr/fm_data_in/fm_wr/fm_rd in; m_data_out/m_busy/m_stall/m_err out). It accepts at most one word request per cycle and routes it to one of four banks selected by address bits [2:1]. It holds each bank busy for a fixed number of cycles and returns read data after a fixed two-cycle pipeline. It is the responder end of the controller's line-fill and evict sequences.

---
 rtl/banked_mem_responder_if.sv | 14 +
 rtl/banked_mem_responder.sv | 53 +++++
 2 files changed

// File: rtl/banked_mem_responder_if.sv
// banked_mem_responder_if: memory-side request/response bus between cache controller (master) and banked memory (slave)
// addr/data_in/wr/rd: word request; data_out: read return beat; busy: per-bank occupancy; stall/err: same-cycle refusal
interface banked_mem_responder_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        wr;
  logic        rd;
  logic [3:0]  busy;
  logic        stall;
  logic        err;
  modport master(output addr, data_in, wr, rd, input data_out, busy, stall, err);
  modport slave(input addr, data_in, wr, rd, output data_out, busy, stall, err);
endinterface

// File: rtl/banked_mem_responder.sv
// banked_mem_responder: four-bank interleaved 32Kx16 memory, fixed bank occupancy, two-cycle read pipeline
// clk/rst: clock and synchronous active-high reset; bus: slave side of banked_mem_responder_if
module banked_mem_responder #(
  parameter int BANK_CYCLES = 4
) (
  input logic                   clk,
  input logic                   rst,
  banked_mem_responder_if.slave bus
);
  logic [15:0] r_mem [32768];
  logic [2:0]  r_cnt [4];
  logic        r_v1;
  logic        r_v2;
  logic [14:0] r_idx1;
  logic [15:0] r_d2;
  logic        w_req;
  logic        w_err;
  logic        w_stall;
  logic        w_acc;
  logic [1:0]  w_bank;
  logic [3:0]  w_busy;
  always_comb begin
    w_busy = '0;
    for (int b = 0; b < 4; b++) w_busy[b] = r_cnt[b] != 3'd0;
  end
  assign w_bank        = bus.addr[2:1];
  assign w_req         = bus.rd | bus.wr;
  assign w_err         = (bus.rd & bus.wr) | (w_req & bus.addr[0]);
  assign w_stall       = ~w_err & w_busy[w_bank] & w_req;
  assign w_acc         = w_req & ~w_err & ~w_stall;
  assign bus.err       = w_err;
  assign bus.stall     = w_stall;
  assign bus.busy      = w_busy;
  assign bus.data_out  = r_v2 ? r_d2 : 16'h0000;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      for (int b = 0; b < 4; b++) r_cnt[b] <= 3'd0;
    end else begin
      r_v1 <= w_acc & bus.rd;
      r_v2 <= r_v1;
      for (int b = 0; b < 4; b++)
        r_cnt[b] <= (w_acc && w_bank == 2'(b)) ? 3'(BANK_CYCLES) : r_cnt[b] - 3'(w_busy[b]);
    end
  end
  // storage and read datapath carry no reset; a write in a reset cycle is dropped
  always_ff @(posedge clk) begin
    if (!rst && w_acc && bus.wr) r_mem[bus.addr[15:1]] <= bus.data_in;
    r_idx1 <= bus.addr[15:1];
    r_d2   <= r_mem[r_idx1];
  end
endmodule
